note_playback_sequencer: RTL and testbench

Reads recorded note records back out of the note RAM, in order, and replays them against its own microsecond timebase. It drives the active note code and a gate to the tone generator. It is the read-side counterpart of the recording path that writes the RAM. It sits between the note RAM's read port and the audio tone generator, and is controlled by the top-level playback/restart states.

---
 rtl/note_playback_sequencer_pkg.sv | 44 ++++
 rtl/note_playback_sequencer_us_timer.sv | 42 ++++
 rtl/note_playback_sequencer.sv | 161 ++++++++++++++++
 tb/tb_note_playback_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_playback_sequencer_pkg.sv
// Shared constants and types for the note record format.
// The recording path builds its records from these same constants.
// Field layout of one 62-bit record: {note[61:58], startUs[57:29], endUs[28:0]}.
package note_playback_sequencer_pkg;

    localparam int REC_W     = 62;
    localparam int NOTE_W    = 4;
    localparam int TIME_W    = 29;

    localparam int NOTE_MSB  = 61;
    localparam int NOTE_LSB  = 58;
    localparam int START_MSB = 57;
    localparam int START_LSB = 29;
    localparam int END_MSB   = 28;
    localparam int END_LSB   = 0;

    // An all-zero record marks the end of the recorded list
    localparam logic [REC_W-1:0] TERMINATOR = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAITDATA,
        ST_WAITSTART,
        ST_PLAYING,
        ST_DONE
    } play_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [TIME_W-1:0] start_us;
        logic [TIME_W-1:0] end_us;
    } note_rec_t;

    // Split a raw RAM word into its named fields
    function automatic note_rec_t unpack_record(input logic [REC_W-1:0] raw);
        note_rec_t rec;
        rec.note     = raw[NOTE_MSB:NOTE_LSB];
        rec.start_us = raw[START_MSB:START_LSB];
        rec.end_us   = raw[END_MSB:END_LSB];
        return rec;
    endfunction

endpackage

// File: rtl/note_playback_sequencer_us_timer.sv
// playback_us_timer: clock prescaler plus a saturating microsecond counter.
// clr has priority over en; the counter holds at all-ones instead of wrapping.
module playback_us_timer #(
    parameter int CLK_PER_US = 50,
    parameter int TIME_W     = 29
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              en,
    output logic [TIME_W-1:0] time_us
);

    localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_US - 1);

    logic [PS_W-1:0]   presc_reg;
    logic [TIME_W-1:0] time_reg;

    // Prescaler divides the clock down to 1 us ticks; counter saturates at max
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_reg <= '0;
            time_reg  <= '0;
        end else if (clr) begin
            presc_reg <= '0;
            time_reg  <= '0;
        end else if (en) begin
            if (presc_reg == PS_LAST) begin
                presc_reg <= '0;
                if (time_reg != '1) begin
                    time_reg <= time_reg + TIME_W'(1);
                end
            end else begin
                presc_reg <= presc_reg + PS_W'(1);
            end
        end
    end

    assign time_us = time_reg;

endmodule

// File: rtl/note_playback_sequencer.sv
// note_playback_sequencer: replays recorded note records from the note RAM
// against a local microsecond timebase, gating the tone generator.
// Optional build macro PLAYBACK_LOOP_EN: end of list restarts playback from
// address 0 / time 0 instead of stopping in DONE.
module note_playback_sequencer
    import note_playback_sequencer_pkg::*;
#(
    parameter int CLK_PER_US = 50,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] readAddress,
    input  logic [REC_W-1:0]  readData,
    output logic              noteActive,
    output logic [NOTE_W-1:0] noteCode,
    output logic [TIME_W-1:0] timeUs,
    output logic              busy,
    output logic              done
);

    play_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    note_rec_t         rec_reg, rec_next;
    logic              active_reg, active_next;
    logic [NOTE_W-1:0] code_reg, code_next;
    logic              done_reg, done_next;

    note_rec_t         incoming;
    logic              go;
    logic              is_term;
    logic              rec_skip;
    logic              step_wd;
    logic              gate_on;
    logic              gate_off;
    logic              advance;
    logic              list_end;
    logic              loop_restart;
    logic              restart;

    // Event decode shared by the next-state and output logic. Control inputs
    // pre-empt every per-state event.
    assign incoming = unpack_record(readData);
    assign go       = !stop && !start;
    assign is_term  = (readData == TERMINATOR);
    // Malformed (end not after start) or already expired records are skipped
    assign rec_skip = (incoming.end_us <= incoming.start_us) || (timeUs >= incoming.end_us);
    assign step_wd  = go && (state_reg == ST_WAITDATA);
    assign gate_on  = go && (state_reg == ST_WAITSTART) && (timeUs >= rec_reg.start_us);
    assign gate_off = go && (state_reg == ST_PLAYING) && (timeUs >= rec_reg.end_us);
    assign advance  = (step_wd && !is_term && rec_skip) || gate_off;
    // Moving past the last address ends the list rather than wrapping to 0
    assign list_end = (step_wd && is_term) || (advance && (addr_reg == '1));

`ifdef PLAYBACK_LOOP_EN
    assign loop_restart = list_end;
`else
    assign loop_restart = 1'b0;
`endif

    assign restart = (start && !stop) || loop_restart;

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            rec_reg    <= '0;
            active_reg <= 1'b0;
            code_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            rec_reg    <= rec_next;
            active_reg <= active_next;
            code_reg   <= code_next;
            done_reg   <= done_next;
        end
    end

    // Next-state selection: stop beats start, start beats everything else
    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (restart) begin
            state_next = ST_FETCH;
        end else if (list_end) begin
            state_next = ST_DONE;
        end else if (advance) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_FETCH:     state_next = ST_WAITDATA;
                ST_WAITDATA:  state_next = ST_WAITSTART;
                ST_WAITSTART: if (gate_on) state_next = ST_PLAYING;
                default:      state_next = state_reg;
            endcase
        end
    end

    // Datapath updates: address, latched record, note gate and done flag
    always_comb begin
        addr_next   = addr_reg;
        rec_next    = rec_reg;
        active_next = active_reg;
        code_next   = code_reg;
        done_next   = done_reg;
        if (stop) begin
            active_next = 1'b0;
            code_next   = '0;
            done_next   = 1'b0;
        end else if (restart) begin
            addr_next   = '0;
            active_next = 1'b0;
            code_next   = '0;
            done_next   = 1'b0;
        end else begin
            if (step_wd) begin
                rec_next = incoming;
            end
            if (gate_on) begin
                active_next = 1'b1;
                code_next   = rec_reg.note;
            end
            if (gate_off) begin
                active_next = 1'b0;
                code_next   = '0;
            end
            if (list_end) begin
                done_next   = 1'b1;
                active_next = 1'b0;
                code_next   = '0;
            end else if (advance) begin
                addr_next = addr_reg + ADDR_W'(1);
            end
        end
    end

    // The timebase runs only while actively sequencing and restarts with playback
    playback_us_timer #(
        .CLK_PER_US (CLK_PER_US),
        .TIME_W     (TIME_W)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (restart),
        .en      (busy),
        .time_us (timeUs)
    );

    assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign readAddress = addr_reg;
    assign noteActive  = active_reg;
    assign noteCode    = code_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_note_playback_sequencer.sv
// Self-checking bench for note_playback_sequencer (CLK_PER_US = 2).
// A behavioural model derives every output from the playback rules: playback
// time is simply (busy cycles since start) / CLK_PER_US, saturated.
// Build with +define+PLAYBACK_LOOP_EN to exercise the looping variant.
module tb_note_playback_sequencer;

    localparam int     CPU   = 2;
    localparam int     AW    = 7;
    localparam int     DEPTH = 128;
    localparam longint TMAX  = (64'd1 << 29) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] readAddress;
    logic [61:0]   readData;
    logic          noteActive;
    logic [3:0]    noteCode;
    logic [28:0]   timeUs;
    logic          busy;
    logic          done;

    logic [61:0]   mem [DEPTH];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model state: phase 0 idle,1 fetch,2 waitdata,3 waitstart,4 playing,5 done
    int     m_phase;
    longint m_cycles;
    int     m_addr;
    bit     m_active;
    int     m_code;
    bit     m_done;
    int     m_nn;
    longint m_ns;
    longint m_ne;

    always #5 clk = ~clk;

    // note RAM with registered read
    always @(posedge clk) readData <= mem[readAddress];

    note_playback_sequencer #(
        .CLK_PER_US (CPU),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .readAddress (readAddress),
        .readData    (readData),
        .noteActive  (noteActive),
        .noteCode    (noteCode),
        .timeUs      (timeUs),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint m_time();
        longint q;
        q = m_cycles / CPU;
        return (q > TMAX) ? TMAX : q;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cycles = 0; m_addr = 0; m_active = 0;
        m_code = 0; m_done = 0; m_nn = 0; m_ns = 0; m_ne = 0;
    endtask

    task automatic begin_play();
        m_phase = 1; m_addr = 0; m_cycles = 0;
        m_done = 0; m_active = 0; m_code = 0;
    endtask

    task automatic finish_list();
`ifdef PLAYBACK_LOOP_EN
        begin_play();
`else
        m_phase = 5; m_done = 1; m_active = 0; m_code = 0;
`endif
    endtask

    task automatic next_record();
        if (m_addr == DEPTH - 1) finish_list();
        else begin
            m_addr++;
            m_phase = 1;
        end
    endtask

    task automatic model_step(input bit s, input bit p);
        logic [61:0] r;
        longint t;
        if (!resetn) begin
            model_reset();
            return;
        end
        t = m_time();
        if (m_phase >= 1 && m_phase <= 4) m_cycles++;
        if (p) begin
            m_phase = 0; m_active = 0; m_code = 0; m_done = 0;
        end else if (s) begin
            begin_play();
        end else begin
            case (m_phase)
                1: m_phase = 2;
                2: begin
                    r = mem[m_addr];
                    if (r == 62'd0) finish_list();
                    else begin
                        m_nn = int'(r[61:58]);
                        m_ns = longint'(r[57:29]);
                        m_ne = longint'(r[28:0]);
                        if (m_ne <= m_ns || t >= m_ne) next_record();
                        else m_phase = 3;
                    end
                end
                3: if (t >= m_ns) begin
                    m_active = 1; m_code = m_nn; m_phase = 4;
                end
                4: if (t >= m_ne) begin
                    m_active = 0; m_code = 0; next_record();
                end
                default: ;
            endcase
        end
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_readAddress", 64'(readAddress), 64'(m_addr));
            check("cyc_noteActive",  64'(noteActive),  64'(m_active));
            check("cyc_noteCode",    64'(noteCode),    64'(m_code));
            check("cyc_timeUs",      64'(timeUs),      64'(m_time()));
            check("cyc_busy",        64'(busy),        64'((m_phase >= 1 && m_phase <= 4) ? 1 : 0));
            check("cyc_done",        64'(done),        64'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit s, input bit p);
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        model_step(s, p);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic set_rec(input int idx, input int note, input int s, input int e);
        mem[idx] = {4'(note), 29'(s), 29'(e)};
    endtask

    function automatic bit cond(input int c);
        case (c)
            0:       return noteActive;
            1:       return !noteActive;
            2:       return done;
            default: return noteActive && (timeUs == 29'd15);
        endcase
    endfunction

    // bounded wait; an expired bound counts as a failed comparison
    task automatic wait_cond(input int c, input int limit, input string name, output int n);
        n = 0;
        while (!cond(c) && n < limit) begin
            tick(0, 0);
            n++;
        end
        check(name, 64'(cond(c)), 64'd1);
    endtask

    task automatic quiesce();
        tick(0, 1);
        tick(0, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int rises;
        int cur, s, e, cnt;
        clear_mem();
        model_reset();
        #12;
        resetn = 1'b1;
        check("rst_readAddress", 64'(readAddress), 64'd0);
        check("rst_noteActive",  64'(noteActive),  64'd0);
        check("rst_timeUs",      64'(timeUs),      64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_done",        64'(done),        64'd0);
        chk_en = 1'b1;

        // scenario 1: single note 3 from 10 to 20
        clear_mem();
        set_rec(0, 3, 10, 20);
        tick(1, 0);
        check("s1_addr_after_start", 64'(readAddress), 64'd0);
        check("s1_busy_after_start", 64'(busy), 64'd1);
        wait_cond(0, 200, "s1_rise_seen", n);
        check("s1_rise_time", 64'(timeUs), 64'd10);
        check("s1_rise_code", 64'(noteCode), 64'd3);
        wait_cond(1, 200, "s1_fall_seen", n);
        check("s1_fall_time", 64'(timeUs), 64'd20);
`ifndef PLAYBACK_LOOP_EN
        wait_cond(2, 50, "s1_done_seen", n);
        check("s1_done_addr", 64'(readAddress), 64'd1);
`endif
        $display("[TB] scenario 1 single note complete");
        quiesce();

        // scenario 2: two back-to-back notes
        clear_mem();
        set_rec(0, 1, 5, 8);
        set_rec(1, 2, 8, 12);
        tick(1, 0);
        wait_cond(0, 200, "s2_rise1_seen", n);
        check("s2_rise1_time", 64'(timeUs), 64'd5);
        check("s2_rise1_code", 64'(noteCode), 64'd1);
        wait_cond(1, 200, "s2_fall1_seen", n);
        wait_cond(0, 20, "s2_rise2_seen", n);
        check("s2_gap_cycles", 64'(n), 64'd3);
        check("s2_rise2_code", 64'(noteCode), 64'd2);
        check("s2_rise2_time", 64'(timeUs), 64'd10);
`ifndef PLAYBACK_LOOP_EN
        wait_cond(2, 200, "s2_done_seen", n);
        check("s2_done_time", 64'(timeUs), 64'd13);
`endif
        $display("[TB] scenario 2 back-to-back notes complete");
        quiesce();

        // scenario 3: malformed record skipped
        clear_mem();
        set_rec(0, 4, 30, 30);
        set_rec(1, 5, 40, 50);
        tick(1, 0);
        wait_cond(0, 300, "s3_rise_seen", n);
        check("s3_first_code", 64'(noteCode), 64'd5);
        check("s3_rise_time", 64'(timeUs), 64'd40);
        wait_cond(1, 200, "s3_fall_seen", n);
        check("s3_fall_time", 64'(timeUs), 64'd50);
        $display("[TB] scenario 3 malformed skip complete");
        quiesce();

        // scenario 4: stop mid-note
        clear_mem();
        set_rec(0, 3, 10, 20);
        tick(1, 0);
        wait_cond(3, 200, "s4_time15_seen", n);
        tick(0, 1);
        check("s4_stop_active", 64'(noteActive), 64'd0);
        check("s4_stop_busy", 64'(busy), 64'd0);
        check("s4_stop_done", 64'(done), 64'd0);
        $display("[TB] scenario 4 stop mid-note complete");
        tick(0, 0);

        // scenario 5: start+stop together, then async reset mid-note
        tick(1, 0);
        wait_cond(0, 200, "s5_rise_seen", n);
        tick(1, 1);
        check("s5_startstop_busy", 64'(busy), 64'd0);
        check("s5_startstop_active", 64'(noteActive), 64'd0);
        tick(1, 0);
        wait_cond(0, 200, "s5_rise2_seen", n);
        #2;
        resetn = 1'b0;
        #1;
        check("s5_rst_active", 64'(noteActive), 64'd0);
        check("s5_rst_code", 64'(noteCode), 64'd0);
        check("s5_rst_time", 64'(timeUs), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_addr", 64'(readAddress), 64'd0);
        check("s5_rst_done", 64'(done), 64'd0);
        model_reset();
        tick(0, 0);
        resetn = 1'b1;
        tick(0, 0);
        $display("[TB] scenario 5 start/stop and reset complete");

        // address overflow: 128 malformed records, no terminator
        for (int i = 0; i < DEPTH; i++) set_rec(i, 1, 5, 5);
        tick(1, 0);
`ifndef PLAYBACK_LOOP_EN
        wait_cond(2, 400, "wrap_done_seen", n);
        check("wrap_addr", 64'(readAddress), 64'd127);
`else
        for (int i = 0; i < 300; i++) tick(0, 0);
        check("wrap_loop_done", 64'(done), 64'd0);
`endif
        $display("[TB] address overflow complete");
        quiesce();

`ifdef PLAYBACK_LOOP_EN
        // scenario 6: looping playback
        clear_mem();
        set_rec(0, 1, 2, 4);
        tick(1, 0);
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            n = int'(noteActive);
            tick(0, 0);
            if (n == 0 && noteActive) rises++;
        end
        check("s6_repeat_gates", 64'(rises >= 3), 64'd1);
        check("s6_done_low", 64'(done), 64'd0);
        $display("[TB] scenario 6 loop complete, %0d gates", rises);
        quiesce();
`endif

        // randomized record lists with random start/stop pulses
        for (int trial = 0; trial < 40; trial++) begin
            clear_mem();
            cnt = $urandom_range(1, 5);
            cur = 0;
            for (int i = 0; i < cnt; i++) begin
                s = cur + $urandom_range(0, 6);
                if ($urandom_range(0, 7) == 0) e = s;
                else e = s + $urandom_range(1, 8);
                set_rec(i, $urandom_range(1, 15), s, e);
                cur = ($urandom_range(0, 3) == 0) ? s : e;
            end
            tick(1, 0);
            for (int c = 0; c < 250; c++) begin
                tick($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0);
            end
            $display("[TB] random trial %0d: %0d records, tests so far %0d", trial, cnt, tests);
            quiesce();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
